// File: rtl/coax_buffered_tx.sv
// coax_buffered_tx: FIFO-fed coax frame transmitter (START, WORDs, END) with bit-cell line coding; optional COAX_BUFFERED_TX_DELAY_EN builds tx_delay.
// Latency: tx/active change one clock after start_strobe is sampled; FIFO full/empty update one clock after push/pop.
// Backpressure: none toward the loader; a load while full is dropped and latched into sticky overflow.

// coax_fifo: generic single-clock FIFO with registered full/empty flags.
// Latency: head word readable combinationally; flags update the clock after the push/pop.
// Backpressure: push_rdy is low while full; pushes without push_rdy are ignored.
module coax_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_rdy = !full;
    assign push_ok  = push_vld && !full;
    assign pop_ok   = pop_vld && !empty;
    assign pop_dat  = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (push_ok && !pop_ok) begin
            count_d = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count - 1'b1;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_d;
            full  <= (count_d == (AW+1)'(DEPTH));
            empty <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

module coax_buffered_tx #(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int DEPTH          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data,
    input  logic       load_strobe,
    input  logic       start_strobe,
    output logic       tx,
    output logic       tx_delay,
    output logic       active,
    output logic       full,
    output logic       empty,
    output logic       overflow
);
    localparam int HALF = CLOCKS_PER_BIT / 2;
    localparam int HCW  = $clog2(HALF);

    // Every segment is counted in half bit cells: START 18, WORD 24, END 4.
    localparam logic [4:0] START_LAST = 5'd17;
    localparam logic [4:0] WORD_LAST  = 5'd23;
    localparam logic [4:0] END_LAST   = 5'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WORD,
        S_END
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [HCW-1:0] half_cyc;
    logic [HCW-1:0] half_cyc_d;
    logic [4:0]     half_idx;
    logic [4:0]     half_idx_d;
    logic [4:0]     last_idx;
    logic [11:0]    word_sr;
    logic [11:0]    word_sr_d;
    logic           tx_d;
    logic           pop_vld;
    logic           push_rdy;
    logic [9:0]     head_dat;

    coax_fifo #(
        .WIDTH (10),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (load_strobe),
        .push_rdy (push_rdy),
        .push_dat (data),
        .pop_vld  (pop_vld),
        .pop_dat  (head_dat),
        .full     (full),
        .empty    (empty)
    );

    // Line level for a given half cell; WORD uses the current MSB of the shift register.
    function automatic logic line_level(input state_t st, input logic [4:0] idx, input logic bit_val);
        logic lvl;
        lvl = 1'b0;
        case (st)
            S_START: begin
                if (idx < 5'd2) begin
                    lvl = 1'b1;
                end else if (idx < 5'd12) begin
                    lvl = idx[0];
                end else if (idx < 5'd15) begin
                    lvl = 1'b0;
                end else begin
                    lvl = 1'b1;
                end
            end
            S_WORD:  lvl = idx[0] ? bit_val : !bit_val;
            S_END:   lvl = (idx != 5'd1);
            default: lvl = 1'b0;
        endcase
        return lvl;
    endfunction

    assign last_idx = (state == S_START) ? START_LAST :
                      (state == S_WORD)  ? WORD_LAST  : END_LAST;

    always_comb begin
        state_d    = state;
        half_cyc_d = half_cyc;
        half_idx_d = half_idx;
        word_sr_d  = word_sr;
        pop_vld    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_strobe && !empty) begin
                    state_d    = S_START;
                    half_cyc_d = '0;
                    half_idx_d = '0;
                end
            end
            default: begin
                if (half_cyc != HCW'(HALF - 1)) begin
                    half_cyc_d = half_cyc + 1'b1;
                end else begin
                    half_cyc_d = '0;
                    if (half_idx != last_idx) begin
                        half_idx_d = half_idx + 1'b1;
                        if (state == S_WORD && half_idx[0]) begin
                            word_sr_d = {word_sr[10:0], 1'b0};
                        end
                    end else begin
                        half_idx_d = '0;
                        if (state == S_END) begin
                            state_d = S_IDLE;
                        end else if (!empty) begin
                            // Pop lands on the first clock of the sync bit.
                            state_d   = S_WORD;
                            pop_vld   = 1'b1;
                            word_sr_d = {1'b1, head_dat, ~^head_dat};
                        end else begin
                            state_d = S_END;
                        end
                    end
                end
            end
        endcase
        tx_d = line_level(state_d, half_idx_d, word_sr_d[11]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            half_cyc <= '0;
            half_idx <= '0;
            word_sr  <= '0;
            tx       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            half_cyc <= half_cyc_d;
            half_idx <= half_idx_d;
            word_sr  <= word_sr_d;
            tx       <= tx_d;
            if (load_strobe && !push_rdy) begin
                overflow <= 1'b1;
            end
        end
    end

    assign active = (state != S_IDLE);

`ifdef COAX_BUFFERED_TX_DELAY_EN
    localparam int DLY = CLOCKS_PER_BIT / 4;
    logic [DLY-1:0] dly_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_sr <= '0;
        end else begin
            dly_sr <= {dly_sr[DLY-2:0], tx};
        end
    end

    assign tx_delay = dly_sr[DLY-1];
`else
    assign tx_delay = 1'b0;
`endif
endmodule

// File: tb/tb_coax_buffered_tx.sv
// tb_coax_buffered_tx: directed + randomized frames checked against a waveform model built from the line-coding rules.
module tb_coax_buffered_tx;
    localparam int CPB   = 8;
    localparam int H     = CPB / 2;
    localparam int DLY   = CPB / 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] data;
    logic       load_strobe;
    logic       start_strobe;
    logic       tx;
    logic       tx_delay;
    logic       active;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0] mq[$];
    logic [9:0] frame_words[$];
    bit         exp_q[$];

    coax_buffered_tx #(
        .CLOCKS_PER_BIT (CPB),
        .DEPTH          (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .load_strobe  (load_strobe),
        .start_strobe (start_strobe),
        .tx           (tx),
        .tx_delay     (tx_delay),
        .active       (active),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add_cells(input bit v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    task automatic add_bit(input bit b);
        add_cells(!b, H);
        add_cells(b, H);
    endtask

    // Expected tx waveform, one entry per clock, for the words in frame_words.
    task automatic build_frame;
        exp_q.delete();
        add_cells(1'b1, CPB);
        repeat (5) add_bit(1'b1);
        add_cells(1'b0, 3 * H);
        add_cells(1'b1, 3 * H);
        foreach (frame_words[w]) begin
            add_bit(1'b1);
            for (int j = 9; j >= 0; j--) add_bit(frame_words[w][j]);
            add_bit(($countones(frame_words[w]) % 2) == 0);
        end
        add_bit(1'b0);
        add_cells(1'b1, CPB);
    endtask

    task automatic load_word(input logic [9:0] d);
        data        = d;
        load_strobe = 1'b1;
        tick();
        load_strobe = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(d);
        check("load_full", full, (mq.size() == DEPTH));
        check("load_empty", empty, (mq.size() == 0));
    endtask

    // Starts a frame and compares every clock; stop_at >= 0 returns mid-frame.
    task automatic run_frame(input string name, input int stop_at, input int load_at,
                             input logic [9:0] load_dat, input int strobe_at);
        int  mis_tx;
        int  mis_act;
        int  mis_dly;
        int  first_bad;
        int  limit;
        bit  exp_dly;
        frame_words = mq;
        if (load_at >= 0) frame_words.push_back(load_dat);
        build_frame();
        mis_tx = 0; mis_act = 0; mis_dly = 0; first_bad = -1;
        start_strobe = 1'b1;
        tick();
        start_strobe = 1'b0;
        limit = (stop_at >= 0) ? stop_at : exp_q.size();
        for (int i = 0; i < limit; i++) begin
`ifdef COAX_BUFFERED_TX_DELAY_EN
            exp_dly = (i >= DLY) ? exp_q[i-DLY] : 1'b0;
`else
            exp_dly = 1'b0;
`endif
            if (tx !== exp_q[i]) begin
                mis_tx++;
                if (first_bad < 0) first_bad = i;
            end
            if (active !== 1'b1) mis_act++;
            if (tx_delay !== exp_dly) mis_dly++;
            load_strobe  = (i == load_at);
            data         = load_dat;
            start_strobe = (i == strobe_at);
            tick();
        end
        load_strobe  = 1'b0;
        start_strobe = 1'b0;
        check($sformatf("%s_tx_mismatches(first@%0d)", name, first_bad), mis_tx, 0);
        check({name, "_active_mismatches"}, mis_act, 0);
        check({name, "_tx_delay_mismatches"}, mis_dly, 0);
        if (stop_at < 0) begin
            mq.delete();
            check({name, "_end_tx"}, tx, 1'b0);
            check({name, "_end_active"}, active, 1'b0);
            check({name, "_end_empty"}, empty, 1'b1);
        end
    endtask

    initial begin
        logic [9:0] w;
        int         n;
        reset        = 1'b1;
        data         = '0;
        load_strobe  = 1'b0;
        start_strobe = 1'b0;
        tick();
        // Strobes during reset must lose to reset.
        data         = 10'h3FF;
        load_strobe  = 1'b1;
        start_strobe = 1'b1;
        tick();
        reset        = 1'b0;
        load_strobe  = 1'b0;
        start_strobe = 1'b0;
        check("rst_tx", tx, 1'b0);
        check("rst_tx_delay", tx_delay, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // Start with an empty FIFO is ignored.
        start_strobe = 1'b1;
        tick();
        start_strobe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("idle_start_tx", tx, 1'b0);
            check("idle_start_active", active, 1'b0);
            tick();
        end

        load_word(10'h001);
        run_frame("single_001", -1, -1, 10'h000, 40);

        load_word(10'h003);
        load_word(10'h000);
        load_word(10'h002);
        run_frame("parity_trio", -1, -1, 10'h000, 200);

        // Nine loads into an eight-deep FIFO: the ninth is dropped.
        for (int i = 0; i < 9; i++) begin
            w = 10'($urandom_range(0, 1023));
            load_word(w);
            if (i == 6) check("fill_not_full_7", full, 1'b0);
            if (i == 7) check("fill_overflow_before_9th", overflow, 1'b0);
        end
        check("fill_full", full, 1'b1);
        check("fill_overflow", overflow, 1'b1);
        check("fill_model_size", mq.size(), DEPTH);
        run_frame("eight_words", -1, -1, 10'h000, 300);
        check("overflow_sticky", overflow, 1'b1);

        // Random frames with a late load joining during START.
        repeat (3) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) load_word(10'($urandom_range(0, 1023)));
            w = 10'($urandom_range(0, 1023));
            run_frame("random", -1, 20, w, 100);
        end

        // Reset in the middle of the 5th data bit of word 2.
        load_word(10'h2A5);
        load_word(10'h15A);
        load_word(10'h0F0);
        run_frame("reset_mid", 9 * CPB + 12 * CPB + CPB + 4 * CPB + 2, -1, 10'h000, -1);
        check("pre_reset_overflow", overflow, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mq.delete();
        check("mid_reset_tx", tx, 1'b0);
        check("mid_reset_active", active, 1'b0);
        check("mid_reset_empty", empty, 1'b1);
        check("mid_reset_full", full, 1'b0);
        check("mid_reset_overflow", overflow, 1'b0);
        check("mid_reset_tx_delay", tx_delay, 1'b0);

        start_strobe = 1'b1;
        tick();
        start_strobe = 1'b0;
        tick();
        check("post_reset_start_active", active, 1'b0);
        check("post_reset_start_tx", tx, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
